mem_port_arbiter: RTL and testbench

//  Shares the single-port 512x16 program/data memory between two masters: port A (CPU) and port B
//  (program loader / DMA). Sits between the masters and memory_512x16 inside the SoC top level.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between masters A and B (optional range check: MEM_PORT_ARB_RANGE_CHK_EN).
// Latency: 3 cycles per access (IDLE sample, ACCESS strobe, DONE ack); at most one access every 3 cycles.
// Backpressure: a master holds req until its ack; a losing request waits for the next IDLE cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [15:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [15:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic              lat_port;    // 0 = A, 1 = B
  logic              lat_we;
  logic              lat_oor;
  logic              last_grant;  // 0 = A, 1 = B
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic              grant_b;
  logic              sel_we;
  logic              sel_oor;
  logic [15:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    grant_b   = b_req & (~a_req | ((FIXED_PRIO == 0) & ~last_grant));
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
  end

`ifdef MEM_PORT_ARB_RANGE_CHK_EN
  assign sel_oor = |sel_addr[15:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |sel_addr[15:ADDR_W];
  assign sel_oor        = 1'b0;
`endif

  // Memory data only arrives in DONE, so the ack cycle sees it directly and the register holds it afterwards.
  assign rd_val  = lat_oor ? {DATA_W{1'b1}} : mem_dout;
  assign a_rdata = (state == DONE && !lat_port && !lat_we) ? rd_val : a_rdata_q;
  assign b_rdata = (state == DONE &&  lat_port && !lat_we) ? rd_val : b_rdata_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= IDLE;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
      last_grant <= 1'b1;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
      err        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state      <= ACCESS;
            lat_port   <= grant_b;
            last_grant <= grant_b;
            lat_we     <= sel_we;
            lat_oor    <= sel_oor;
            mem_read   <= ~sel_we & ~sel_oor;
            mem_write  <=  sel_we & ~sel_oor;
            mem_addr   <= sel_addr[ADDR_W-1:0];
            mem_din    <= sel_wdata;
          end
        end
        ACCESS: begin
          state     <= DONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_addr  <= '0;
          mem_din   <= '0;
          a_ack     <= ~lat_port;
          b_ack     <=  lat_port;
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
          err       <= lat_oor;
`endif
        end
        DONE: begin
          state <= IDLE;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
          err   <= 1'b0;
`endif
          if (!lat_we) begin
            if (lat_port) b_rdata_q <= rd_val;
            else          a_rdata_q <= rd_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model of grants, memory contents and timing.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, mem_read, mem_write, busy;
  logic [15:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [8:0]  mem_addr;
  logic        fp_a_ack, fp_b_ack, fp_mem_read, fp_mem_write, fp_busy;
  logic [15:0] fp_a_rdata, fp_b_rdata, fp_mem_din;
  logic [15:0] fp_mem_dout = 16'h0000;
  logic [8:0]  fp_mem_addr;
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
  logic        err, fp_err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_b(rst_b),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
    , .err(err)
`endif
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_b(rst_b),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(fp_a_ack), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(fp_b_ack), .b_rdata(fp_b_rdata),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr), .mem_din(fp_mem_din),
    .mem_dout(fp_mem_dout), .busy(fp_busy)
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
    , .err(fp_err)
`endif
  );

  // Synchronous 512x16 memory; cleared on reset so the model can start from zero.
  logic [15:0] mem [512];
  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_din;
      if (mem_read)  mem_dout <= mem[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [15:0] shadow [512];
  logic [15:0] exp_a_rdata, exp_b_rdata, t_wdata, t_rdval;
  logic [8:0]  t_addr;
  logic        t_port, t_we, t_oor, model_last, rst_pending, did_rst4;
  int          next_sample, acc_cyc, done_cyc, fp_a_cnt;

  task automatic model_reset();
    for (int i = 0; i < 512; i++) shadow[i] = '0;
    exp_a_rdata = '0; exp_b_rdata = '0;
    t_port = 1'b0; t_we = 1'b0; t_oor = 1'b0; t_addr = '0; t_wdata = '0; t_rdval = '0;
    model_last = 1'b1;
    acc_cyc = -1; done_cyc = -1;
    next_sample = cyc;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 16'h01FF;
      1:       return 16'h0000;
      2:       return 16'h0200;
      3:       return 16'($urandom);
      4, 5:    return 16'($urandom_range(0, 7));
      default: return 16'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic next_req(input int mode, input logic req, input logic ack,
                          inout logic we, inout logic [15:0] addr, inout logic [15:0] wdata,
                          output logic nreq);
    logic fresh;
    fresh = 1'b0;
    if (mode == 1) begin
      nreq  = 1'b1;
      fresh = ack || !req;
    end else if (req && ack) begin
      nreq  = 1'($urandom_range(0, 1));
      fresh = nreq;
    end else if (req) begin
      nreq = ($urandom_range(0, 9) != 0);
    end else begin
      nreq  = ($urandom_range(0, 2) == 0);
      fresh = nreq;
    end
    if (fresh) begin
      we    = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      addr  = rand_addr();
      wdata = 16'($urandom);
    end
  endtask

  task automatic step(input int mode, input logic force_rst);
    logic acc, done, do_rst, nr, win;
    logic [15:0] full;
    @(negedge clk);
    if (rst_pending) model_reset();
    acc  = (cyc == acc_cyc);
    done = (cyc == done_cyc);
    if (done && !t_we) begin
      if (t_port) exp_b_rdata = t_rdval;
      else        exp_a_rdata = t_rdval;
    end
    check("mem_read",  mem_read,  acc && !t_we && !t_oor);
    check("mem_write", mem_write, acc &&  t_we && !t_oor);
    if (acc && !t_oor) check("mem_addr", mem_addr, t_addr);
    if (acc && t_we && !t_oor) check("mem_din", mem_din, t_wdata);
    check("a_ack",   a_ack,   done && !t_port);
    check("b_ack",   b_ack,   done &&  t_port);
    check("a_rdata", a_rdata, exp_a_rdata);
    check("b_rdata", b_rdata, exp_b_rdata);
    check("busy",    busy,    acc || done);
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
    check("err", err, done && t_oor);
`endif
    if (mode == 1) begin
      check("fp_b_ack", fp_b_ack, 1'b0);
      fp_a_cnt += int'(fp_a_ack);
    end

    do_rst = force_rst;
    if (mode == 0 && $urandom_range(0, 99) == 0) do_rst = 1'b1;
    if (mode == 0 && !did_rst4 && acc && t_port && !t_we) begin
      do_rst   = 1'b1;
      did_rst4 = 1'b1;
    end

    next_req(mode, a_req, a_ack, a_we, a_addr, a_wdata, nr); a_req = nr;
    next_req(mode, b_req, b_ack, b_we, b_addr, b_wdata, nr); b_req = nr;
    rst_b = do_rst;

    if (!do_rst && cyc == next_sample) begin
      if (a_req || b_req) begin
        if (a_req && b_req) win = (dut_fp_mode_sel(0)) ? 1'b0 : !model_last;
        else                win = b_req;
        model_last = win;
        t_port  = win;
        t_we    = win ? b_we : a_we;
        full    = win ? b_addr : a_addr;
        t_wdata = win ? b_wdata : a_wdata;
        t_addr  = full[8:0];
`ifdef MEM_PORT_ARB_RANGE_CHK_EN
        t_oor   = (full >= 16'd512);
`else
        t_oor   = 1'b0;
`endif
        t_rdval = t_oor ? 16'hFFFF : shadow[t_addr];
        if (t_we && !t_oor) shadow[t_addr] = t_wdata;
        acc_cyc     = cyc + 1;
        done_cyc    = cyc + 2;
        next_sample = cyc + 3;
      end else begin
        next_sample = cyc + 1;
      end
    end
    rst_pending = do_rst;
    cyc++;
  endtask

  // The main instance is round-robin; fixed priority is exercised only through dut_fp.
  function automatic logic dut_fp_mode_sel(input int fixed);
    return (fixed != 0);
  endfunction

  initial begin
    rst_b = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    did_rst4 = 1'b0; fp_a_cnt = 0;
    repeat (2) @(posedge clk);
    rst_pending = 1'b1;
    for (int i = 0; i < 3000; i++) step(0, 1'b0);
    step(0, 1'b1);
    fp_a_cnt = 0;
    for (int i = 0; i < 30; i++) step(1, 1'b0);
    check("fp_a_ack_count", fp_a_cnt, 10);
    check("reset_during_b_read_seen", did_rst4, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
